// File: rtl/seq0010_scan_ctrl.sv
// seq0010_scan_ctrl: word-level controller around a serial "0010" Mealy detector.
//
// A word captured on an accepted start is shifted MSB first, one bit per clock, into the
// embedded detector. Detections are pulsed on match and counted (saturating) in match_cnt.
// Detector state carries across words unless flush is sampled high with the accepted start.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   start      scan request, honoured only in IDLE
//   flush      with an accepted start: clear the detector to D0 before the first bit
//   data_in    word to scan, captured on accepted start
//   busy       high in SHIFT and DONE
//   done       one-cycle pulse, word fully scanned
//   match      one-cycle registered pulse per detection
//   match_cnt  detections in the current word, saturating; holds until next accepted start
//   det_state  detector state encoding D0..D3 (debug)
//
// Configuration macro: SEQ_OVERLAP_EN
//   defined     - detection in D3 goes to D1, so the trailing "0" starts the next pattern
//   not defined - detection in D3 goes to D0, matches are non-overlapping

module seq0010_scan_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [WORD_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [1:0]        det_state
);

  localparam int unsigned BitW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } ctrl_e;

  typedef enum logic [1:0] {
    DetD0 = 2'd0,
    DetD1 = 2'd1,
    DetD2 = 2'd2,
    DetD3 = 2'd3
  } det_e;

  ctrl_e             ctrl_q, ctrl_d;
  det_e              det_q, det_d;
  det_e              det_nxt;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              match_q, match_d;
  logic              bit_in;
  logic              hit;

  assign bit_in = shreg_q[WORD_W-1];

  // Detector transition for the bit currently at the head of the shift register.
  always_comb begin
    det_nxt = det_q;
    hit     = 1'b0;
    case (det_q)
      DetD0: det_nxt = bit_in ? DetD0 : DetD1;
      DetD1: det_nxt = bit_in ? DetD0 : DetD2;
      DetD2: det_nxt = bit_in ? DetD3 : DetD2;
      DetD3: begin
        if (bit_in) begin
          det_nxt = DetD0;
        end else begin
          hit = 1'b1;
`ifdef SEQ_OVERLAP_EN
          det_nxt = DetD1;
`else
          det_nxt = DetD0;
`endif
        end
      end
      default: det_nxt = DetD0;
    endcase
  end

  // Controller next state; the detector only advances while shifting.
  always_comb begin
    ctrl_d    = ctrl_q;
    det_d     = det_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    match_d   = 1'b0;
    case (ctrl_q)
      StIdle: begin
        if (start) begin
          shreg_d   = data_in;
          bit_cnt_d = '0;
          cnt_d     = '0;
          if (flush) begin
            det_d = DetD0;
          end
          ctrl_d = StShift;
        end
      end
      StShift: begin
        det_d     = det_nxt;
        match_d   = hit;
        if (hit && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BitW'(1);
        if (bit_cnt_q == LastBit) begin
          ctrl_d = StDone;
        end
      end
      StDone: begin
        ctrl_d = StIdle;
      end
      default: begin
        ctrl_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= StIdle;
      det_q     <= DetD0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      det_q     <= det_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
    end
  end

  assign busy      = (ctrl_q != StIdle);
  assign done      = (ctrl_q == StDone);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign det_state = det_q;

endmodule

// File: tb/tb_seq0010_scan_ctrl.sv
// Directed bench for seq0010_scan_ctrl: a vector table of words with hand-computed match
// masks, final counts and detector states, plus hand-written sequences for reset, held
// start, mid-scan reset and counter saturation on a 16-bit instance.

module tb_seq0010_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       flush;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic       match;
  logic [3:0] match_cnt;
  logic [1:0] det_state;

  logic        b_start;
  logic        b_flush;
  logic [15:0] b_data;
  logic        b_busy;
  logic        b_done;
  logic        b_match;
  logic [1:0]  b_match_cnt;
  logic [1:0]  b_det_state;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [7:0] data;
    logic       flush;
    logic [7:0] mask;  // bit i set: match expected after the edge consuming bit i
    logic [3:0] cnt;
    logic [1:0] det;
  } vec_t;

  vec_t vecs[10];

  seq0010_scan_ctrl #(
    .WORD_W(8),
    .CNT_W (4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .match    (match),
    .match_cnt(match_cnt),
    .det_state(det_state)
  );

  seq0010_scan_ctrl #(
    .WORD_W(16),
    .CNT_W (2)
  ) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .start    (b_start),
    .flush    (b_flush),
    .data_in  (b_data),
    .busy     (b_busy),
    .done     (b_done),
    .match    (b_match),
    .match_cnt(b_match_cnt),
    .det_state(b_det_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    start   = 1'b1;
    flush   = v.flush;
    data_in = v.data;
    step();
    start   = 1'b0;
    flush   = 1'b0;
    data_in = 8'h00;
    check($sformatf("v%0d busy_after_accept", idx), busy, 1);
    check($sformatf("v%0d cnt_cleared", idx), match_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("v%0d match_bit%0d", idx, i), match, v.mask[i]);
      if (i < 7) check($sformatf("v%0d done_low_bit%0d", idx, i), done, 0);
    end
    check($sformatf("v%0d done", idx), done, 1);
    check($sformatf("v%0d busy_in_done", idx), busy, 1);
    check($sformatf("v%0d match_cnt", idx), match_cnt, v.cnt);
    check($sformatf("v%0d det_state", idx), det_state, v.det);
    step();
    check($sformatf("v%0d idle_busy", idx), busy, 0);
    check($sformatf("v%0d idle_done", idx), done, 0);
    check($sformatf("v%0d cnt_hold", idx), match_cnt, v.cnt);
    step();
    check($sformatf("v%0d det_hold", idx), det_state, v.det);
  endtask

  initial begin
    int pulses;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    flush   = 1'b0;
    data_in = 8'h00;
    b_start = 1'b0;
    b_flush = 1'b0;
    b_data  = 16'h0000;

`ifdef SEQ_OVERLAP_EN
    vecs[0] = '{8'h24, 1'b1, 8'h48, 4'd2, 2'd2};
    vecs[6] = '{8'h22, 1'b1, 8'h88, 4'd2, 2'd1};
    vecs[7] = '{8'h92, 1'b0, 8'h90, 4'd2, 2'd1};
`else
    vecs[0] = '{8'h24, 1'b1, 8'h08, 4'd1, 2'd2};
    vecs[6] = '{8'h22, 1'b1, 8'h88, 4'd2, 2'd0};
    vecs[7] = '{8'h92, 1'b0, 8'h10, 4'd1, 2'd1};
`endif
    vecs[1] = '{8'h01, 1'b1, 8'h00, 4'd0, 2'd3};
    vecs[2] = '{8'h00, 1'b0, 8'h01, 4'd1, 2'd2};  // pattern spans the word boundary
    vecs[3] = '{8'h01, 1'b1, 8'h00, 4'd0, 2'd3};
    vecs[4] = '{8'h00, 1'b1, 8'h00, 4'd0, 2'd2};  // flush breaks the spanning pattern
    vecs[5] = '{8'hFF, 1'b1, 8'h00, 4'd0, 2'd0};
    vecs[8] = '{8'h01, 1'b1, 8'h00, 4'd0, 2'd3};
    vecs[9] = '{8'hA0, 1'b0, 8'h00, 4'd0, 2'd2};  // D3 with 1 falls back to D0

    step();
    step();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst match", match, 0);
    check("rst match_cnt", match_cnt, 0);
    check("rst det_state", det_state, 0);
    rst = 1'b0;
    step();
    check("idle det_state", det_state, 0);

    // 16-bit instance, 2-bit counter saturates at 3
    b_start = 1'b1;
    b_flush = 1'b1;
    b_data  = 16'h2492;
    step();
    b_start = 1'b0;
    b_flush = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (b_match) pulses++;
    end
`ifdef SEQ_OVERLAP_EN
    check("w16 pulses", pulses, 5);
    check("w16 det_state", b_det_state, 1);
`else
    check("w16 pulses", pulses, 3);
    check("w16 det_state", b_det_state, 0);
`endif
    check("w16 done", b_done, 1);
    check("w16 match_cnt_sat", b_match_cnt, 3);
    step();
    check("w16 idle busy", b_busy, 0);

    for (int v = 0; v < 10; v++) begin
      run_vec(vecs[v], v);
    end

    // Start held high: only IDLE edges (every 10 cycles) capture data_in.
    start = 1'b1;
    flush = 1'b1;
    for (int k = 0; k < 30; k++) begin
      data_in = ((k % 10) == 0) ? 8'h22 : 8'hFF;
      step();
      check($sformatf("held busy k%0d", k), busy, ((k % 10) != 9));
      check($sformatf("held done k%0d", k), done, ((k % 10) == 8));
      if ((k % 10) == 8) check($sformatf("held cnt k%0d", k), match_cnt, 2);
    end
    start   = 1'b0;
    flush   = 1'b0;
    data_in = 8'h00;
    step();

    // Reset sampled at E4, the edge that would otherwise pulse match.
    start   = 1'b1;
    flush   = 1'b1;
    data_in = 8'h24;
    step();
    start   = 1'b0;
    flush   = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst match", match, 0);
    check("midrst match_cnt", match_cnt, 0);
    check("midrst det_state", det_state, 0);
    check("midrst done", done, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("midrst no_done k%0d", k), done, 0);
    end
    run_vec(vecs[0], 10);

    // Simultaneous rst and start: rst wins.
    rst     = 1'b1;
    start   = 1'b1;
    data_in = 8'h24;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start busy", busy, 0);
    step();
    check("rst_start still_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
